// File: rtl/mult4_mac_pkg.sv
// Shared types and widths for the 4x4 multiply-accumulate block.
// Provides the FSM state enum and the operand/product/accumulator widths.
package mult4_mac_pkg;

  localparam int LEN_W     = 4;
  localparam int PROD_W    = 8;
  localparam int MIN_ACC_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mult4_mac_accum_core.sv
// mult4_core: combinational unsigned 4x4 -> 8 multiplier.
// Ports: a, b (4-bit unsigned operands), p (8-bit exact product).
module mult4_core
  import mult4_mac_pkg::*;
(
  input  logic [3:0]        a,
  input  logic [3:0]        b,
  output logic [PROD_W-1:0] p
);

  assign p = {4'b0, a} * {4'b0, b};

endmodule

// File: rtl/mult4_mac_accum.sv
// Job-based multiply-accumulate: sums len+1 products of 4-bit beats.
// Ports: clk, rst_n, start/len job request, in_valid/in_ready/a/b
// operand beats, out_valid/out_ready/acc result, busy status.
module mult4_mac_accum
  import mult4_mac_pkg::*;
#(
  parameter int ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a,
  input  logic [3:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic             busy
);

  state_t              state;
  logic [LEN_W-1:0]    cnt;
  logic [LEN_W-1:0]    len_q;
  logic [PROD_W-1:0]   prod_q;
  logic                prod_v;
  logic [PROD_W-1:0]   prod_d;
  logic [ACC_W-1:0]    prod_ext;

  mult4_core u_core (
    .a (a),
    .b (b),
    .p (prod_d)
  );

  assign prod_ext = {{(ACC_W-PROD_W){1'b0}}, prod_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      prod_q    <= '0;
      prod_v    <= 1'b0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      prod_v <= 1'b0;
      // Product registered last edge lands in acc now.
      if (prod_v)
        acc <= acc + prod_ext;
      unique case (state)
        IDLE: begin
          if (start) begin
            acc      <= '0;
            cnt      <= '0;
            len_q    <= len;
            state    <= ACCUM;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            prod_q <= prod_d;
            prod_v <= 1'b1;
            cnt    <= cnt + 1'b1;
            if (cnt == len_q) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult4_mac_accum.sv
// Directed scoreboard bench for mult4_mac_accum.
// Runs a 16-bit and a 12-bit accumulator instance side by side.
module tb_mult4_mac_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] acc;
  logic        busy;

  logic        in_ready12;
  logic        out_valid12;
  logic [11:0] acc12;
  logic        busy12;

  int n_chk  = 0;
  int n_fail = 0;
  int run_sum;
  int exp_q[$];

  always #5 clk = ~clk;

  mult4_mac_accum #(.ACC_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc       (acc),
    .busy      (busy)
  );

  mult4_mac_accum #(.ACC_W(12)) dut12 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready12),
    .a         (a),
    .b         (b),
    .out_valid (out_valid12),
    .out_ready (out_ready),
    .acc       (acc12),
    .busy      (busy12)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [3:0] l);
    chk("idle_in_ready", in_ready, 0);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_accum", in_ready, 1);
    chk("acc_cleared", acc, 0);
    run_sum = 0;
  endtask

  task automatic beat(input logic [3:0] x,
                      input logic [3:0] y,
                      input int gap,
                      input bit last);
    int n;
    repeat (gap) begin
      tick();
      chk("busy_gap", busy, 1);
      chk("in_ready_gap", in_ready, 1);
    end
    in_valid = 1'b1;
    a = x;
    b = y;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("beat_wait_bound", n < 20, 1);
    tick();
    in_valid = 1'b0;
    run_sum += int'(x) * int'(y);
    chk("busy_beat", busy, 1);
    if (last) begin
      exp_q.push_back(run_sum & 16'hFFFF);
      chk("drain_in_ready", in_ready, 0);
      chk("drain_out_valid", out_valid, 0);
      tick();
      chk("out_valid_latency", out_valid, 1);
      chk("done_in_ready", in_ready, 0);
      chk("done_busy", busy, 1);
    end
  endtask

  task automatic finish_job(input int hold, input bit poke);
    int n;
    int e;
    logic [15:0] a0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("result_wait_bound", n < 20, 1);
    a0 = acc;
    repeat (hold) begin
      start    = poke;
      in_valid = 1'b1;
      a        = 4'hF;
      b        = 4'hF;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_acc", acc, a0);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_busy", busy, 1);
    end
    chk("sb_nonempty", exp_q.size() > 0, 1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    chk("acc16", acc, e);
    chk("acc12", acc12, e & 12'hFFF);
    out_ready = 1'b1;
    start     = poke;
    len       = 4'd0;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("post_out_valid", out_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_in_ready", in_ready, 0);
    chk("post_acc_kept", acc, e);
    tick();
    chk("idle_stays_busy0", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    len       = 4'd0;
    in_valid  = 1'b0;
    a         = 4'd0;
    b         = 4'd0;
    out_ready = 1'b0;
    #3;
    chk("rst_acc", acc, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    start_job(4'd0);
    beat(4'd15, 4'd15, 0, 1);
    finish_job(0, 0);

    start_job(4'd15);
    for (int i = 0; i < 16; i++)
      beat(4'd15, 4'd15, (i % 3 == 1) ? 1 : 0, i == 15);
    finish_job(1, 0);

    start_job(4'd2);
    beat(4'd3, 4'd4, 0, 0);
    beat(4'd0, 4'd9, 2, 0);
    beat(4'd7, 4'd7, 2, 1);
    finish_job(5, 1);

    start_job(4'd3);
    beat(4'd1, 4'd2, 0, 0);
    beat(4'd3, 4'd4, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_acc", acc, 0);
    chk("abort_acc12", acc12, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    repeat (5) begin
      tick();
      chk("abort_no_result", out_valid, 0);
      chk("abort_idle", busy, 0);
    end
    start_job(4'd0);
    beat(4'd2, 4'd3, 0, 1);
    finish_job(0, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
